// File: rtl/cordic_lut_loader_pkg.sv
// cordic_lut_loader_pkg: LUT geometry and loader states shared with the CORDIC core and its bench
package cordic_lut_loader_pkg;
  localparam int LUT_WIDTH = 48;
  localparam int LUT_DEPTH = 64;
  localparam int LUT_INDEX_W = 6;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;
endpackage

// File: rtl/lut_word_packer.sv
// lut_word_packer: shifts bytes MSB-first into a LUT word and flags the final byte of each word
module lut_word_packer
  import cordic_lut_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           data,
  output logic [LUT_WIDTH-1:0] word_next,
  output logic                 last
);
  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  logic [LUT_WIDTH-1:0] word;
  logic [CW-1:0]        cnt;
  always_comb begin
    word_next = {word[LUT_WIDTH-9:0], data};
    last = shift_en && cnt == CW'(BYTES_PER_WORD - 1);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      word <= word_next;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cordic_lut_loader.sv
// cordic_lut_loader: streams bytes into 48-bit words and writes them to the CORDIC LUT, then enables run mode
module cordic_lut_loader
  import cordic_lut_loader_pkg::*;
#(
  parameter int WORDS = LUT_DEPTH,
  parameter int BYTES_PER_WORD = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [LUT_INDEX_W-1:0] lut_index,
  output logic [LUT_WIDTH-1:0]   lut_data,
  output logic                   lut_we,
  output logic                   core_wen,
  output logic                   done,
  output logic                   busy
);
  state_t                 state;
  logic [LUT_INDEX_W-1:0] wcnt;
  logic [LUT_WIDTH-1:0]   word_next;
  logic                   last;
  logic                   shift_en;
  assign shift_en = s_valid && s_ready && !abort;
  lut_word_packer #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_packer (
    .clk(clk),
    .rst(reset),
    .clear(abort),
    .shift_en(shift_en),
    .data(s_data),
    .word_next(word_next),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      s_ready <= 1'b0;
      lut_index <= '0;
      lut_data <= '0;
      lut_we <= 1'b0;
      core_wen <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      lut_we <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        wcnt <= '0;
        s_ready <= 1'b0;
        core_wen <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE, RUN: if (start) begin
            state <= LOAD;
            wcnt <= '0;
            s_ready <= 1'b1;
            core_wen <= 1'b0;
            busy <= 1'b1;
          end
          LOAD: if (last) begin
            state <= WRITE;
            s_ready <= 1'b0;
            lut_we <= 1'b1;
            lut_data <= word_next;
            lut_index <= wcnt;
          end
          WRITE: if (wcnt == LUT_INDEX_W'(WORDS - 1)) begin
            state <= RUN;
            done <= 1'b1;
            core_wen <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= LOAD;
            wcnt <= wcnt + LUT_INDEX_W'(1);
            s_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cordic_lut_loader.sv
// tb_cordic_lut_loader: randomized stimulus with a byte-stream reference model and a LUT write scoreboard
module tb_cordic_lut_loader;
  import cordic_lut_loader_pkg::*;
  localparam int BPW = 6;
  logic clk = 0, reset = 1, start = 0, abort = 0, s_valid = 0;
  logic [7:0] s_data = 0;
  logic s_ready, lut_we, core_wen, done, busy;
  logic [LUT_INDEX_W-1:0] lut_index;
  logic [LUT_WIDTH-1:0] lut_data;
  int checks = 0, errors = 0;
  int done_cnt = 0, cyc = 0, last_we = -1, widx = 0;
  bit gap_on = 0, word0_on = 0;
  int exp_idx[$];
  logic [LUT_WIDTH-1:0] exp_dat[$];
  logic [7:0] wbytes[$];

  always #5 clk = ~clk;

  cordic_lut_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .lut_index(lut_index), .lut_data(lut_data), .lut_we(lut_we),
    .core_wen(core_wen), .done(done), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    wbytes.delete();
    widx = 0;
    last_we = -1;
  endtask

  task automatic model_push(input logic [7:0] b);
    logic [LUT_WIDTH-1:0] d;
    wbytes.push_back(b);
    if (wbytes.size() == BPW) begin
      d = 0;
      foreach (wbytes[i]) d = d * 256 + LUT_WIDTH'(wbytes[i]);
      exp_idx.push_back(widx);
      exp_dat.push_back(d);
      widx++;
      wbytes.delete();
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (lut_we) begin
      chk("we_ready", {s_ready, busy, core_wen}, 3'b010);
      if (gap_on && last_we >= 0) chk("we_gap", cyc - last_we, 7);
      last_we = cyc;
      if (word0_on) begin
        chk("word0", lut_data, 48'h000102030405);
        word0_on = 0;
      end
      if (exp_idx.size() == 0) begin
        chk("unexpected_we", {lut_index, lut_data}, 0);
      end else begin
        chk("lut_index", lut_index, exp_idx.pop_front());
        chk("lut_data", lut_data, exp_dat.pop_front());
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1;
    model_clear();
    @(negedge clk) start = 0;
  endtask

  task automatic send(input int n, input bit gaps, input bit pattern, input bit rnd_start);
    int k = 0, budget = 0;
    logic [7:0] b = 8'($urandom);
    while (k < n && budget < 20000) begin
      @(negedge clk);
      budget++;
      s_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      s_data = pattern ? 8'(k % 128) : b;
      start = rnd_start && $urandom_range(19, 0) == 0;
      if (s_valid && s_ready) begin
        model_push(s_data);
        k++;
        b = 8'($urandom);
      end
    end
    if (k < n) chk("send_timeout", k, n);
    @(negedge clk);
    s_valid = 0;
    start = 0;
  endtask

  task automatic wait_done(input int target);
    int budget = 0;
    while (done_cnt < target && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    chk("done_cnt", done_cnt, target);
    repeat (3) @(negedge clk);
    chk("run_state", {core_wen, busy, s_ready}, 3'b100);
    chk("queue_empty", exp_idx.size(), 0);
    chk("done_once", done_cnt, target);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", {s_ready, lut_we, lut_index, lut_data, core_wen, done, busy}, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_out", {s_ready, busy, core_wen}, 0);

    gap_on = 1;
    word0_on = 1;
    pulse_start();
    chk("load_busy", {busy, s_ready}, 2'b11);
    send(LUT_DEPTH * BPW, 0, 1, 0);
    wait_done(1);
    gap_on = 0;

    pulse_start();
    chk("reload_wen", {core_wen, busy}, 2'b01);
    send(LUT_DEPTH * BPW, 1, 1, 1);
    wait_done(2);

    pulse_start();
    send(100, 1, 0, 0);
    @(negedge clk);
    abort = 1;
    s_valid = 1;
    s_data = 8'($urandom);
    @(negedge clk);
    abort = 0;
    s_valid = 0;
    chk("abort_idle", {busy, s_ready, core_wen, lut_we}, 0);
    chk("abort_queue", exp_idx.size(), 0);
    pulse_start();
    send(LUT_DEPTH * BPW, 1, 0, 0);
    wait_done(3);

    pulse_start();
    send(10 * BPW + 2, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    s_valid = 1;
    model_clear();
    @(negedge clk);
    chk("midload_reset", {s_ready, lut_we, lut_index, lut_data, core_wen, done, busy}, 0);
    reset = 0;
    s_valid = 0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy, s_ready, core_wen}, 0);

    pulse_start();
    send(3, 0, 0, 0);
    @(negedge clk);
    start = 1;
    abort = 1;
    s_valid = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("start_abort", {busy, s_ready, core_wen}, 0);
    repeat (10) @(negedge clk);
    s_valid = 0;
    chk("no_load", {busy, s_ready, core_wen}, 0);
    chk("final_queue", exp_idx.size(), 0);
    chk("final_done", done_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_lut_loader.md
CORDIC_LUT_LOADER -- requirements
Module: cordic_lut_loader

Interface
REQ-001 SHALL have parameter WORDS, default 64, meaning LUT depth written to the CORDIC core.
REQ-002 SHALL have parameter BYTES_PER_WORD, default 6, meaning input bytes assembled per 48-bit LUT word.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle request to begin or restart a LUT load.
REQ-006 SHALL have port abort, input, 1, meaning cancel the load in progress and return to IDLE.
REQ-007 SHALL have port s_data, input, 8, meaning the LUT byte stream, most significant byte of each word first.
REQ-008 SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-009 SHALL have port s_ready, output, 1, meaning the loader accepts s_data this cycle.
REQ-010 SHALL have port lut_index, output, 6, meaning the core write address (index_wri).
REQ-011 SHALL have port lut_data, output, 48, meaning the core write data (D).
REQ-012 SHALL have port lut_we, output, 1, meaning a one-cycle write strobe for lut_index/lut_data.
REQ-013 SHALL have port core_wen, output, 1, meaning the core mode: 0 = table load, 1 = run (drives the core's wen).
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse when the full table has been written.
REQ-015 SHALL have port busy, output, 1, meaning high in LOAD or WRITE.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE and RUN.
REQ-017 IDLE SHALL go to LOAD on start; RUN SHALL go to LOAD on start (reload), with core_wen dropping to 0 the next cycle.
REQ-018 LOAD SHALL drive s_ready=1 and accept a byte on each cycle with s_valid&&s_ready, shifting it into a 48-bit assembly register (first byte -> bits 47:40).
REQ-019 Acceptance of the BYTES_PER_WORD-th byte SHALL move to WRITE; the next cycle SHALL show lut_we=1 with lut_data = the assembled word and lut_index = word counter.
REQ-020 WRITE SHALL last exactly one cycle with s_ready=0, then increment the word counter and return to LOAD, or go to RUN after index WORDS-1.
REQ-021 Entry into RUN SHALL pulse done for one cycle and set core_wen=1; core_wen SHALL be 0 in every other state.
REQ-022 Minimum throughput SHALL be BYTES_PER_WORD+1 cycles per word; s_valid gaps SHALL stall without corrupting the assembly.
REQ-023 The word counter SHALL wrap only through reload; indices SHALL be written strictly 0..WORDS-1 with none skipped or repeated.
REQ-024 abort SHALL take priority over start and over byte acceptance: go to IDLE and clear the byte count, word count and assembly register; the byte presented that cycle SHALL be discarded.
REQ-025 start in LOAD or WRITE SHALL be ignored.
REQ-026 lut_index and lut_data SHALL hold their last values outside WRITE; lut_we SHALL be 0 outside WRITE.

Reset
REQ-027 reset SHALL dominate abort and start and SHALL force IDLE, s_ready=0, lut_we=0, lut_index=0, lut_data=0, core_wen=0, done=0, busy=0, and cleared counters.
REQ-028 Reset mid-load SHALL discard the partial word; no lut_we SHALL occur in the reset cycle or the cycle after.

Structure
REQ-029 A shared package SHALL hold the state enumeration, LUT_WIDTH=48, LUT_DEPTH=64 and LUT_INDEX_W=6, shared with the CORDIC core and its bench.
REQ-030 The byte-to-word assembler (shift register plus byte counter) SHALL be one sub-module named lut_word_packer; the FSM and word counter SHALL stay in the top level.

Verification
REQ-031 Reset, start, then 384 back-to-back bytes 0x00..0x7F repeating -> 64 lut_we pulses 7 cycles apart; word 0 = 0x000102030405; done pulses once; core_wen=1 afterwards.
REQ-032 Random s_valid gaps (50% duty) over a full load -> identical lut_index/lut_data sequence to REQ-031; s_ready=0 in every WRITE cycle.
REQ-033 abort after 100 bytes, then start and a full load -> indices restart at 0 with no stale data; done pulses once.
REQ-034 reset asserted during the 3rd byte of word 10 -> all outputs at reset values; no lut_we for index 10.
REQ-035 start while in RUN -> core_wen=0 the next cycle; full reload completes; core_wen returns to 1 with a second done pulse.
REQ-036 start asserted in the same cycle as abort during LOAD -> IDLE; no load begins.
